wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency multi-cycle unit (mul/div).
- Multi-cycle results go into a small FIFO and drain into idle port cycles.
- A starvation timer forces a pipeline stall so buffered results always retire.
- Sits between WB, the MC unit, and the regfile write port.

---
 rtl/wb_arb_pkg.sv | 39 +++
 rtl/wb_result_fifo.sv | 141 ++++++++++++++
 rtl/wb_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types for the writeback-port arbiter:
//   - REG_ADDR_W / XLEN : register address and data widths
//   - state_e           : arbiter FSM states (NORMAL, STARVE)
//   - entry_t           : one buffered multi-cycle result {live, rd, wdata}
//   - sat_add()         : saturating add used by the optional perf counters
//                         (built with WB_ARB_PERF_EN)
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } state_e;

    // live=0 marks an entry that must retire without touching the regfile
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wdata;
    } entry_t;

    // Add that sticks at all-ones instead of wrapping
    function automatic logic [XLEN-1:0] sat_add(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[XLEN]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[XLEN-1:0];
        end
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// Circular buffer of multi-cycle results with a per-entry kill-by-rd compare.
// A pipeline write to rd clears the live bit of every buffered entry with the
// same rd, including an entry being pushed in that same cycle.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   push, push_entry     write an entry at the tail (caller guarantees not full)
//   pop                  drop the head (caller guarantees not empty)
//   kill_en, kill_rd     kill every live entry whose rd equals kill_rd
//   head                 entry at the head slot
//   count                number of occupied slots
//   any_live             at least one occupied slot is still live
//   kill_num             entries killed this cycle (WB_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  entry_t                push_entry,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output entry_t                head,
    output logic [CNT_W-1:0]      count,
    output logic                  any_live
`ifdef WB_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]      kill_num
`endif
);

    entry_t           mem_r      [DEPTH];
    entry_t           mem_next_s [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             any_live_r;
    logic             any_live_next_s;
    logic             push_killed_s;
`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0] kill_num_s;
`endif

    // Next storage image: apply kills, retire the popped slot, then write the push.
    // Popped slots are cleared to non-live so only occupied slots can be live.
    always_comb begin
        mem_next_s = mem_r;
`ifdef WB_ARB_PERF_EN
        kill_num_s = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && mem_r[i].live && (mem_r[i].rd == kill_rd)) begin
                mem_next_s[i].live = 1'b0;
`ifdef WB_ARB_PERF_EN
                kill_num_s = kill_num_s + CNT_W'(1'b1);
`endif
            end else begin
                mem_next_s[i].live = mem_r[i].live;
            end
        end
        if (pop) begin
            mem_next_s[rd_ptr_r].live = 1'b0;
        end else begin
            mem_next_s[rd_ptr_r].live = mem_next_s[rd_ptr_r].live;
        end
        // A result is older than a same-cycle pipeline write to the same rd
        push_killed_s = push_entry.live && kill_en && (push_entry.rd == kill_rd);
        if (push) begin
            mem_next_s[wr_ptr_r]      = push_entry;
            mem_next_s[wr_ptr_r].live = push_entry.live && !push_killed_s;
`ifdef WB_ARB_PERF_EN
            if (push_killed_s) begin
                kill_num_s = kill_num_s + CNT_W'(1'b1);
            end else begin
                kill_num_s = kill_num_s;
            end
`endif
        end else begin
            mem_next_s[wr_ptr_r] = mem_next_s[wr_ptr_r];
        end
    end

    // Occupancy and live summary of the next storage image
    always_comb begin
        any_live_next_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_live_next_s = any_live_next_s | mem_next_s[i].live;
        end
        case ({push, pop})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            any_live_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_next_s[i];
            end
            // Pointers wrap naturally because DEPTH is a power of two
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_next_s;
            any_live_r <= any_live_next_s;
        end
    end

    assign head     = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign any_live = any_live_r;
`ifdef WB_ARB_PERF_EN
    assign kill_num = kill_num_s;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single regfile write port between the in-order pipeline WB stage
// and a multi-cycle (mul/div) unit. MC results are buffered and drain into
// idle port cycles; a starvation timer forces a one-cycle pipeline stall so a
// buffered result always retires. Writes to x0 never use the port.
// Optional build macro: WB_ARB_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   pipe_we_i, pipe_rd_i, pipe_wdata_i pipeline WB write request
//   mc_valid_i, mc_ready_o            MC result handshake
//   mc_rd_i, mc_wdata_i               MC result destination and data
//   rf_we_o, rf_rd_o, rf_wdata_o      registered regfile write port
//   stall_pipe_o                      pipeline must hold its WB request
//   pending_o                         buffer holds at least one live result
//   perf_stall_cnt_o                  cycles spent in STARVE   (WB_ARB_PERF_EN)
//   perf_kill_cnt_o                   buffered results killed  (WB_ARB_PERF_EN)
//   perf_full_cnt_o                   cycles an MC result met a full buffer
//                                     (WB_ARB_PERF_EN)
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_we_i,
    input  logic [REG_ADDR_W-1:0] pipe_rd_i,
    input  logic [XLEN-1:0]       pipe_wdata_i,
    input  logic                  mc_valid_i,
    output logic                  mc_ready_o,
    input  logic [REG_ADDR_W-1:0] mc_rd_i,
    input  logic [XLEN-1:0]       mc_wdata_i,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_rd_o,
    output logic [XLEN-1:0]       rf_wdata_o,
    output logic                  stall_pipe_o,
    output logic                  pending_o
`ifdef WB_ARB_PERF_EN
    ,
    output logic [XLEN-1:0]       perf_stall_cnt_o,
    output logic [XLEN-1:0]       perf_kill_cnt_o,
    output logic [XLEN-1:0]       perf_full_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT - 1);

    state_e                state_r;
    state_e                state_next_s;
    logic [AGE_W-1:0]      age_r;
    logic [AGE_W-1:0]      age_next_s;
    logic                  stall_r;
    logic                  rf_we_r;
    logic [REG_ADDR_W-1:0] rf_rd_r;
    logic [XLEN-1:0]       rf_wdata_r;

    logic                  pipe_req_s;
    logic                  head_valid_s;
    logic                  head_live_s;
    logic                  head_dead_s;
    logic                  mc_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  grant_pipe_s;
    logic                  grant_head_s;
    entry_t                push_entry_s;
    entry_t                head_s;
    logic [CNT_W-1:0]      count_s;
    logic                  any_live_s;
`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0]      kill_num_s;
    logic [XLEN-1:0]       stall_cnt_r;
    logic [XLEN-1:0]       kill_cnt_r;
    logic [XLEN-1:0]       full_cnt_r;
`endif

    // Request qualification and buffer handshake
    always_comb begin
        pipe_req_s         = pipe_we_i && (pipe_rd_i != '0);
        head_valid_s       = (count_s != '0);
        head_live_s        = head_valid_s && head_s.live;
        head_dead_s        = head_valid_s && !head_s.live;
        mc_ready_s         = (count_s != FULL_CNT);
        push_s             = mc_valid_i && mc_ready_s;
        // Results for x0 are accepted but never reach the port
        push_entry_s.live  = (mc_rd_i != '0);
        push_entry_s.rd    = mc_rd_i;
        push_entry_s.wdata = mc_wdata_i;
    end

    // Port arbitration, pop decision and starvation timer
    always_comb begin
        state_next_s = state_r;
        age_next_s   = age_r;
        grant_pipe_s = 1'b0;
        grant_head_s = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            NORMAL: begin
                if (pipe_req_s) begin
                    grant_pipe_s = 1'b1;
                    // A killed head retires alongside the pipeline grant
                    pop_s        = head_dead_s;
                    if (head_live_s) begin
                        if (age_r == AGE_LIMIT) begin
                            state_next_s = STARVE;
                        end else begin
                            age_next_s = age_r + AGE_W'(1'b1);
                        end
                    end else begin
                        age_next_s = '0;
                    end
                end else if (head_live_s) begin
                    grant_head_s = 1'b1;
                    pop_s        = 1'b1;
                    age_next_s   = '0;
                end else begin
                    pop_s      = head_dead_s;
                    age_next_s = '0;
                end
            end
            STARVE: begin
                // Pipeline request is held off; the head retires (or is
                // dropped if a kill reached it before the stall took effect)
                grant_head_s = head_live_s;
                pop_s        = head_valid_s;
                age_next_s   = '0;
                state_next_s = NORMAL;
            end
            default: begin
                state_next_s = NORMAL;
                age_next_s   = '0;
            end
        endcase
    end

    // FSM state, age counter and registered port/stall outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= NORMAL;
            age_r      <= '0;
            stall_r    <= 1'b0;
            rf_we_r    <= 1'b0;
            rf_rd_r    <= '0;
            rf_wdata_r <= '0;
        end else begin
            state_r <= state_next_s;
            age_r   <= age_next_s;
            stall_r <= (state_next_s == STARVE);
            rf_we_r <= grant_pipe_s || grant_head_s;
            if (grant_pipe_s) begin
                rf_rd_r    <= pipe_rd_i;
                rf_wdata_r <= pipe_wdata_i;
            end else if (grant_head_s) begin
                rf_rd_r    <= head_s.rd;
                rf_wdata_r <= head_s.wdata;
            end else begin
                rf_rd_r    <= '0;
                rf_wdata_r <= '0;
            end
        end
    end

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .kill_en    (grant_pipe_s),
        .kill_rd    (pipe_rd_i),
        .head       (head_s),
        .count      (count_s),
        .any_live   (any_live_s)
`ifdef WB_ARB_PERF_EN
        ,
        .kill_num   (kill_num_s)
`endif
    );

`ifdef WB_ARB_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
            kill_cnt_r  <= '0;
            full_cnt_r  <= '0;
        end else begin
            if (state_r == STARVE) begin
                stall_cnt_r <= sat_add(stall_cnt_r, XLEN'(1'b1));
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            kill_cnt_r <= sat_add(kill_cnt_r, XLEN'(kill_num_s));
            if (mc_valid_i && !mc_ready_s) begin
                full_cnt_r <= sat_add(full_cnt_r, XLEN'(1'b1));
            end else begin
                full_cnt_r <= full_cnt_r;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_r;
    assign perf_kill_cnt_o  = kill_cnt_r;
    assign perf_full_cnt_o  = full_cnt_r;
`endif

    assign mc_ready_o   = mc_ready_s;
    assign rf_we_o      = rf_we_r;
    assign rf_rd_o      = rf_rd_r;
    assign rf_wdata_o   = rf_wdata_r;
    assign stall_pipe_o = stall_r;
    assign pending_o    = any_live_s;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios followed by randomized traffic checked against a
// queue-based reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_wdata_i;
    logic        mc_valid_i;
    logic        mc_ready_o;
    logic [4:0]  mc_rd_i;
    logic [31:0] mc_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wdata_o;
    logic        stall_pipe_o;
    logic        pending_o;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_kill_cnt_o;
    logic [31:0] perf_full_cnt_o;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_we_i    (pipe_we_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_wdata_i (pipe_wdata_i),
        .mc_valid_i   (mc_valid_i),
        .mc_ready_o   (mc_ready_o),
        .mc_rd_i      (mc_rd_i),
        .mc_wdata_i   (mc_wdata_i),
        .rf_we_o      (rf_we_o),
        .rf_rd_o      (rf_rd_o),
        .rf_wdata_o   (rf_wdata_o),
        .stall_pipe_o (stall_pipe_o),
        .pending_o    (pending_o)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_kill_cnt_o  (perf_kill_cnt_o),
        .perf_full_cnt_o  (perf_full_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered results as a plain queue, oldest first
    typedef struct {
        bit          live;
        logic [4:0]  rd;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      mq[$];
    bit          m_starve = 1'b0;
    int          m_age    = 0;
    longint      m_stall_cnt = 0;
    longint      m_kill_cnt  = 0;
    longint      m_full_cnt  = 0;
    bit          exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    bit          exp_ready_pre;
    logic        obs_ready_pre;

    function automatic bit m_pending();
        foreach (mq[i]) if (mq[i].live) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input bit rst, input bit pwe, input logic [4:0] prd,
                              input logic [31:0] pdata, input bit mv,
                              input logic [4:0] mrd, input logic [31:0] mdata);
        bit pipe_req, ready, h_exist, h_live, gp;
        exp_we = 1'b0; exp_rd = 5'd0; exp_wdata = 32'd0;
        if (rst) begin
            mq.delete();
            m_starve = 1'b0; m_age = 0;
            m_stall_cnt = 0; m_kill_cnt = 0; m_full_cnt = 0;
            return;
        end
        pipe_req = pwe && (prd != 5'd0);
        ready    = (mq.size() < DEPTH);
        h_exist  = (mq.size() > 0);
        h_live   = h_exist && mq[0].live;
        gp       = 1'b0;
        if (mv && !ready) m_full_cnt++;
        if (m_starve) begin
            m_stall_cnt++;
            if (h_live) begin exp_we = 1'b1; exp_rd = mq[0].rd; exp_wdata = mq[0].data; end
            if (h_exist) void'(mq.pop_front());
            m_starve = 1'b0; m_age = 0;
        end else if (pipe_req) begin
            gp = 1'b1;
            exp_we = 1'b1; exp_rd = prd; exp_wdata = pdata;
            if (h_live) begin
                if (m_age == MAX_WAIT - 1) m_starve = 1'b1;
                else m_age++;
            end else begin
                m_age = 0;
            end
            if (h_exist && !h_live) void'(mq.pop_front());
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].rd == prd) begin mq[i].live = 1'b0; m_kill_cnt++; end
            end
        end else begin
            m_age = 0;
            if (h_live) begin exp_we = 1'b1; exp_rd = mq[0].rd; exp_wdata = mq[0].data; end
            if (h_exist) void'(mq.pop_front());
        end
        if (mv && ready) begin
            m_ent_t e;
            e.rd = mrd; e.data = mdata;
            e.live = (mrd != 5'd0) && !(gp && mrd == prd);
            if ((mrd != 5'd0) && gp && (mrd == prd)) m_kill_cnt++;
            mq.push_back(e);
        end
    endtask

    // Drive one cycle of inputs, update the model, then sample after the edge
    task automatic cycle(input bit rst, input bit pwe, input logic [4:0] prd,
                         input logic [31:0] pdata, input bit mv,
                         input logic [4:0] mrd, input logic [31:0] mdata);
        rst_n = ~rst; pipe_we_i = pwe; pipe_rd_i = prd; pipe_wdata_i = pdata;
        mc_valid_i = mv; mc_rd_i = mrd; mc_wdata_i = mdata;
        obs_ready_pre = mc_ready_o;
        exp_ready_pre = (mq.size() < DEPTH);
        model_step(rst, pwe, prd, pdata, mv, mrd, mdata);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        bit seen;
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b expected 0", rf_we_o); end
        n_checks++; if (mc_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", mc_ready_o); end
        n_checks++; if (stall_pipe_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_pipe_o); end
        n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", pending_o); end
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'(9 + k), 32'h900 + 32'(k));
        n_checks++; if (pending_o !== 1'b1) begin n_fail++; $display("FAIL midop_pending: got %b expected 1", pending_o); end
        cycle(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC00);
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rf_we: got %b expected 0", rf_we_o); end
        n_checks++; if (mc_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", mc_ready_o); end
        n_checks++; if (stall_pipe_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", stall_pipe_o); end
        n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL midrst_pending: got %b expected 0", pending_o); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle();
            if (rf_we_o !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_stale_write: got 1 expected 0"); end
    endtask

    task automatic test_idle_drain();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL drain_push_we: got %b expected 0", rf_we_o); end
        n_checks++; if (pending_o !== 1'b1) begin n_fail++; $display("FAIL drain_pending: got %b expected 1", pending_o); end
        idle();
        n_checks++; if (rf_we_o !== 1'b1) begin n_fail++; $display("FAIL drain_we: got %b expected 1", rf_we_o); end
        n_checks++; if (rf_rd_o !== 5'd5) begin n_fail++; $display("FAIL drain_rd: got %0d expected 5", rf_rd_o); end
        n_checks++; if (rf_wdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL drain_data: got %h expected deadbeef", rf_wdata_o); end
        idle();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL drain_after_we: got %b expected 0", rf_we_o); end
    endtask

    task automatic test_starvation();
        cycle(1'b0, 1'b1, 5'd3, 32'h333, 1'b1, 5'd4, 32'h4444_4444);
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd3) begin n_fail++; $display("FAIL starve_first_pipe: got we=%b rd=%0d expected we=1 rd=3", rf_we_o, rf_rd_o); end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'd0);
            n_checks++;
            if (stall_pipe_o !== (i == 8)) begin n_fail++; $display("FAIL starve_stall_%0d: got %b expected %b", i, stall_pipe_o, (i == 8)); end
        end
        cycle(1'b0, 1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'd0);
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd4 || rf_wdata_o !== 32'h4444_4444) begin
            n_fail++; $display("FAIL starve_forced: got we=%b rd=%0d data=%h expected we=1 rd=4 data=44444444", rf_we_o, rf_rd_o, rf_wdata_o); end
        n_checks++; if (stall_pipe_o !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b expected 0", stall_pipe_o); end
        cycle(1'b0, 1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'd0);
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd3 || rf_wdata_o !== 32'h333) begin
            n_fail++; $display("FAIL starve_pipe_retire: got we=%b rd=%0d data=%h expected we=1 rd=3 data=333", rf_we_o, rf_rd_o, rf_wdata_o); end
        idle();
    endtask

    task automatic test_kill();
        cycle(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd7, 32'h11);
        n_checks++; if (pending_o !== 1'b1) begin n_fail++; $display("FAIL kill_pending_before: got %b expected 1", pending_o); end
        cycle(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd7 || rf_wdata_o !== 32'h22) begin
            n_fail++; $display("FAIL kill_pipe_write: got we=%b rd=%0d data=%h expected we=1 rd=7 data=22", rf_we_o, rf_rd_o, rf_wdata_o); end
        n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL kill_pending_after: got %b expected 0", pending_o); end
        idle();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL kill_silent_pop: got %b expected 0", rf_we_o); end
        idle();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL kill_no_late_write: got %b expected 0", rf_we_o); end
`ifdef WB_ARB_PERF_EN
        n_checks++; if (perf_kill_cnt_o !== 32'd1) begin n_fail++; $display("FAIL kill_perf: got %0d expected 1", perf_kill_cnt_o); end
`endif
    endtask

    task automatic test_full();
        logic [4:0]  got_rd[$];
        logic [31:0] got_data[$];
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'(10 + k), 32'hA0 + 32'(k));
            if (rf_we_o && rf_rd_o >= 5'd10) begin got_rd.push_back(rf_rd_o); got_data.push_back(rf_wdata_o); end
        end
        n_checks++; if (mc_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_after4: got %b expected 0", mc_ready_o); end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hA4);
            if (rf_we_o && rf_rd_o >= 5'd10) begin got_rd.push_back(rf_rd_o); got_data.push_back(rf_wdata_o); end
            n_checks++; if (mc_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_hold_%0d: got %b expected 0", k, mc_ready_o); end
        end
        cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hA4);
        if (rf_we_o && rf_rd_o >= 5'd10) begin got_rd.push_back(rf_rd_o); got_data.push_back(rf_wdata_o); end
        n_checks++; if (mc_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_drain: got %b expected 1", mc_ready_o); end
        cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hA4);
        if (rf_we_o && rf_rd_o >= 5'd10) begin got_rd.push_back(rf_rd_o); got_data.push_back(rf_wdata_o); end
        for (int k = 0; k < 20; k++) begin
            idle();
            if (rf_we_o && rf_rd_o >= 5'd10) begin got_rd.push_back(rf_rd_o); got_data.push_back(rf_wdata_o); end
        end
        n_checks++; if (got_rd.size() != 5) begin n_fail++; $display("FAIL full_count: got %0d expected 5", got_rd.size()); end
        for (int k = 0; k < 5 && k < got_rd.size(); k++) begin
            n_checks++;
            if (got_rd[k] !== 5'(10 + k) || got_data[k] !== 32'hA0 + 32'(k)) begin
                n_fail++; $display("FAIL full_order_%0d: got rd=%0d data=%h expected rd=%0d data=%h", k, got_rd[k], got_data[k], 10 + k, 32'hA0 + 32'(k)); end
        end
    endtask

    task automatic test_x0();
        cycle(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_pipe: got %b expected 0", rf_we_o); end
        n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL x0_pending: got %b expected 0", pending_o); end
        idle();
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_mc_pop: got %b expected 0", rf_we_o); end
        idle();
        n_checks++; if (rf_we_o !== 1'b0 || mc_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_after: got we=%b ready=%b expected we=0 ready=1", rf_we_o, mc_ready_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            n_checks++; if (obs_ready_pre !== exp_ready_pre) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b expected %b", n, obs_ready_pre, exp_ready_pre); end
            n_checks++; if (rf_we_o !== exp_we) begin n_fail++; $display("FAIL rnd_we @%0d: got %b expected %b", n, rf_we_o, exp_we); end
            if (exp_we) begin
                n_checks++;
                if (rf_rd_o !== exp_rd || rf_wdata_o !== exp_wdata) begin
                    n_fail++; $display("FAIL rnd_write @%0d: got rd=%0d data=%h expected rd=%0d data=%h", n, rf_rd_o, rf_wdata_o, exp_rd, exp_wdata); end
            end
            n_checks++; if (stall_pipe_o !== m_starve) begin n_fail++; $display("FAIL rnd_stall @%0d: got %b expected %b", n, stall_pipe_o, m_starve); end
            n_checks++; if (pending_o !== m_pending()) begin n_fail++; $display("FAIL rnd_pending @%0d: got %b expected %b", n, pending_o, m_pending()); end
`ifdef WB_ARB_PERF_EN
            n_checks++;
            if (perf_stall_cnt_o !== 32'(m_stall_cnt) || perf_kill_cnt_o !== 32'(m_kill_cnt) || perf_full_cnt_o !== 32'(m_full_cnt)) begin
                n_fail++; $display("FAIL rnd_perf @%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, perf_stall_cnt_o, perf_kill_cnt_o,
                                   perf_full_cnt_o, m_stall_cnt, m_kill_cnt, m_full_cnt); end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; pipe_we_i = 1'b0; pipe_rd_i = 5'd0; pipe_wdata_i = 32'd0;
        mc_valid_i = 1'b0; mc_rd_i = 5'd0; mc_wdata_i = 32'd0;
        test_reset();
        test_idle_drain();
        test_starvation();
        test_kill();
        test_full();
        test_x0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
